// File: rtl/pipelined_main_memory_if.sv
// Request/response bus for pipelined_main_memory.
// Optional feature macro: MEM_MISALIGN_CHK_EN (adds o_misaligned).
interface pipelined_main_memory_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              i_enable;
  logic              i_wr;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_data_in;
  logic [DATA_W-1:0] o_data_out;
  logic              o_data_valid;
  logic              o_busy;
`ifdef MEM_MISALIGN_CHK_EN
  logic              o_misaligned;

  modport master (
    output i_enable, i_wr, i_addr, i_data_in,
    input  o_data_out, o_data_valid, o_busy, o_misaligned
  );
  modport slave (
    input  i_enable, i_wr, i_addr, i_data_in,
    output o_data_out, o_data_valid, o_busy, o_misaligned
  );
`else
  modport master (
    output i_enable, i_wr, i_addr, i_data_in,
    input  o_data_out, o_data_valid, o_busy
  );
  modport slave (
    input  i_enable, i_wr, i_addr, i_data_in,
    output o_data_out, o_data_valid, o_busy
  );
`endif
endinterface

// File: rtl/pipelined_main_memory.sv
// Word-organised main memory with a fixed, fully pipelined read latency.
// Reads sample the array at issue and ride a LATENCY-deep {valid,data}
// shift pipeline; writes commit immediately and are never answered.
// Optional feature macro: MEM_MISALIGN_CHK_EN
//   defined     : reads flag addr[0]=1 via o_misaligned, writes with addr[0]=1 are dropped
//   not defined : addr[0] is ignored for reads and writes
module pipelined_main_memory #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 4
) (
  input logic                    i_clk,
  input logic                    i_rst,
  pipelined_main_memory_if.slave bus
);
  localparam int WORDS = 2 ** (ADDR_W - 1);

  // Contents are deliberately not reset: committed data survives rst.
  logic [DATA_W-1:0] r_mem [WORDS];

  logic [ADDR_W-2:0]  w_idx;
  logic               w_rd;
  logic               w_wr;
  logic [DATA_W-1:0]  w_rd_data;

  logic [LATENCY-1:0] r_vld;
  logic [DATA_W-1:0]  r_data [LATENCY];
  logic [LATENCY-1:0] w_vld_in;
  logic [DATA_W-1:0]  w_data_in [LATENCY];

  assign w_idx     = bus.i_addr[ADDR_W-1:1];
  assign w_rd      = bus.i_enable & ~bus.i_wr;
  assign w_rd_data = r_mem[w_idx];

`ifdef MEM_MISALIGN_CHK_EN
  logic [LATENCY-1:0] r_mis;
  logic [LATENCY-1:0] w_mis_in;

  assign w_wr = bus.i_enable & bus.i_wr & ~bus.i_addr[0];
`else
  logic w_unused_addr_lsb;

  assign w_unused_addr_lsb = bus.i_addr[0];
  assign w_wr              = bus.i_enable & bus.i_wr;
`endif

  // Array write port; a request during reset is discarded.
  always_ff @(posedge i_clk) begin
    if (w_wr && !i_rst) begin
      r_mem[w_idx] <= bus.i_data_in;
    end
  end

  // Stage inputs: stage 0 takes the fresh array read, later stages the previous stage.
  always_comb begin
    w_vld_in     = '0;
    w_vld_in[0]  = w_rd;
    w_data_in[0] = w_rd_data;
    for (int i = 1; i < LATENCY; i++) begin
      w_vld_in[i]  = r_vld[i-1];
      w_data_in[i] = r_data[i-1];
    end
  end

  // Read pipeline; the last data stage only loads on a valid read so
  // o_data_out holds the previous word between pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_vld <= w_vld_in;
      for (int i = 0; i < LATENCY; i++) begin
        if ((i < LATENCY - 1) || w_vld_in[i]) begin
          r_data[i] <= w_data_in[i];
        end
      end
    end
  end

`ifdef MEM_MISALIGN_CHK_EN
  // Per-stage copy of each read's addr[0].
  always_comb begin
    w_mis_in    = '0;
    w_mis_in[0] = bus.i_addr[0];
    for (int i = 1; i < LATENCY; i++) begin
      w_mis_in[i] = r_mis[i-1];
    end
  end

  // Misalignment flag pipeline, aligned with r_vld.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mis <= '0;
    end else begin
      r_mis <= w_mis_in;
    end
  end

  assign bus.o_misaligned = r_vld[LATENCY-1] & r_mis[LATENCY-1];
`endif

  assign bus.o_data_valid = r_vld[LATENCY-1];
  assign bus.o_data_out   = r_data[LATENCY-1];
  assign bus.o_busy       = |r_vld;

endmodule

// File: tb/tb_pipelined_main_memory.sv
// Directed self-checking bench for pipelined_main_memory (LATENCY=4).
// Inputs are driven and outputs sampled on the falling edge.
module tb_pipelined_main_memory;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int LATENCY = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipelined_main_memory_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  pipelined_main_memory #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LATENCY)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
    bus.i_enable  = en;
    bus.i_wr      = w;
    bus.i_addr    = a;
    bus.i_data_in = d;
  endtask

  task automatic idle();
    set_req(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic nc();
    @(negedge clk);
  endtask

  task automatic write_word(input logic [15:0] a, input logic [15:0] d);
    set_req(1'b1, 1'b1, a, d);
    nc();
    idle();
  endtask

  task automatic read_check(input string tag, input logic [15:0] a, input logic [15:0] exp);
    set_req(1'b1, 1'b0, a, 16'h0000);
    for (int i = 1; i <= LATENCY; i++) begin
      nc();
      idle();
    end
    check({tag, "_valid"}, 32'(bus.o_data_valid), 32'd1);
    check({tag, "_data"}, 32'(bus.o_data_out), 32'(exp));
`ifdef MEM_MISALIGN_CHK_EN
    check({tag, "_misal"}, 32'(bus.o_misaligned), 32'(a[0]));
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset then idle
    rst = 1'b1;
    idle();
    nc();
    check("rst_valid", 32'(bus.o_data_valid), 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    nc();
    check("rst_data", 32'(bus.o_data_out), 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      nc();
      check("idle_valid", 32'(bus.o_data_valid), 32'd0);
      check("idle_busy", 32'(bus.o_busy), 32'd0);
      check("idle_data", 32'(bus.o_data_out), 32'h0);
    end

    // Single read latency: write c0, read c1, response c5
    write_word(16'h0040, 16'hBEEF);
    set_req(1'b1, 1'b0, 16'h0040, 16'h0000);
    for (int k = 2; k <= 6; k++) begin
      nc();
      idle();
      check("lat_busy", 32'(bus.o_busy), 32'(k <= 5));
      check("lat_valid", 32'(bus.o_data_valid), 32'(k == 5));
      if (k >= 5) check("lat_data", 32'(bus.o_data_out), 32'hBEEF);
    end

    // Block-fill burst
    for (int i = 0; i < 8; i++) begin
      write_word(16'(16'h0120 + 2 * i), 16'(16'h1230 + i));
    end
    for (int k = 0; k <= 12; k++) begin
      if (k < 8) set_req(1'b1, 1'b0, 16'(16'h0120 + 2 * k), 16'h0000);
      else idle();
      check("burst_valid", 32'(bus.o_data_valid), 32'(k >= 4 && k <= 11));
      check("burst_busy", 32'(bus.o_busy), 32'(k >= 1 && k <= 11));
      if (k >= 4 && k <= 11) check("burst_data", 32'(bus.o_data_out), 32'(16'h1230 + (k - 4)));
      nc();
    end

    // Read-then-write hazard
    write_word(16'h0200, 16'h0001);
    for (int k = 0; k <= 7; k++) begin
      if (k == 0 || k == 2) set_req(1'b1, 1'b0, 16'h0200, 16'h0000);
      else if (k == 1) set_req(1'b1, 1'b1, 16'h0200, 16'h0002);
      else idle();
      check("haz_valid", 32'(bus.o_data_valid), 32'(k == 4 || k == 6));
      if (k == 4) check("haz_old", 32'(bus.o_data_out), 32'h0001);
      if (k == 6) check("haz_new", 32'(bus.o_data_out), 32'h0002);
      nc();
    end

    // Reset mid-flight
    for (int k = 0; k < 3; k++) begin
      set_req(1'b1, 1'b0, 16'(16'h0120 + 2 * k), 16'h0000);
      nc();
    end
    idle();
    rst = 1'b1;
    #1;
    check("mrst_busy", 32'(bus.o_busy), 32'd0);
    check("mrst_valid", 32'(bus.o_data_valid), 32'd0);
    nc();
    rst = 1'b0;
    check("mrst_data", 32'(bus.o_data_out), 32'h0);
    for (int k = 4; k <= 12; k++) begin
      check("mrst_no_valid", 32'(bus.o_data_valid), 32'd0);
      check("mrst_no_busy", 32'(bus.o_busy), 32'd0);
      nc();
    end
    read_check("keep_0040", 16'h0040, 16'hBEEF);
    read_check("keep_0126", 16'h0126, 16'h1233);

    // Top of address space: 0xFFFE and 0xFFFF share a word
    write_word(16'hFFFE, 16'h1357);
    read_check("top_word", 16'hFFFF, 16'h1357);
    nc();
    check("hold_data", 32'(bus.o_data_out), 32'h1357);

    // Misaligned access
    read_check("misal_rd", 16'h0041, 16'hBEEF);
    write_word(16'h0041, 16'hAAAA);
`ifdef MEM_MISALIGN_CHK_EN
    read_check("misal_wr", 16'h0040, 16'hBEEF);
`else
    read_check("misal_wr", 16'h0040, 16'hAAAA);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
